// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receive path.
package uart_pkg;

  localparam int   CLKS_PER_BIT_DEF = 434;
  localparam int   UART_DATA_W      = 8;
  localparam logic LINE_IDLE        = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous serial input, plus a delayed
// copy of the synced level so a falling edge can be detected.
module rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic meta;
  logic rx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= LINE_IDLE;
      rx_s <= LINE_IDLE;
      rx_d <= LINE_IDLE;
    end else begin
      meta <= rx;
      rx_s <= meta;
      rx_d <= rx_s;
    end
  end

  assign rx_fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 receiver with a one-byte holding register and
// framing/overrun pulses; define UART_RX_PARITY_EN for 8E1 with parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rs232_rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                   parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_W);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_STOP   = STOP;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = PARITY;
`endif

  logic [2:0]             state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          bit_idx;
  logic [UART_DATA_W-1:0] shift;
  logic                   rx_s;
  logic                   rx_fall;
  logic                   bit_done;
  logic                   byte_good;

  rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx      (rs232_rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign bit_done = (cnt == BIT_LAST);
  assign busy     = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_good;
  assign par_good  = ~^{shift, par_bit};
  assign byte_good = rx_s & par_good;
`else
  assign byte_good = rx_s;
`endif

  // The stop sample returns to IDLE on the same edge, re-arming mid-stop-bit
  // so a following start edge is caught without losing a character.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state   <= ST_START;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end

        // A start bit that is high again at mid-bit was only a glitch.
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[UART_DATA_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_done) begin
            cnt       <= '0;
            state     <= ST_IDLE;
            frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err <= ~par_good;
`endif
            if (byte_good) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly upstream of the loopback core: it oversamples the asynchronous `rs232_rx` line and deframes 8N1 characters (optionally 8E1). It delivers each byte on a valid/ready handshake with a one-byte holding register. Framing and overrun faults are reported as single-cycle pulses, so the core can mirror them on LEDs.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 baud), clock cycles per bit; legal range ≥ 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock domain only.
- `rs232_rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  received byte; stable while `rx_valid` is high.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid && rx_ready` at a rising edge.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while the holding register was full and not being accepted.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- Input path: 2-FF synchronizer, then a registered copy for edge detection. All three flops reset to 1.
- Start detection is edge-based: the synced line was 1 on the previous cycle and is 0 now. A line held low never retriggers.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE → START on a falling edge; the bit counter loads 0.
  - START: count to `CLKS_PER_BIT/2 - 1` (integer division), then sample. If the sample is 0, go to DATA and clear the counter. If it is 1, treat it as a glitch and return to IDLE with no outputs.
  - DATA: sample every `CLKS_PER_BIT` cycles. Shift LSB-first into an 8-bit shift register. After bit 7, go to PARITY (macro on) or STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles and return to IDLE in the same edge. This re-arms mid-stop-bit, so back-to-back characters are received.
- Stop sample = 1: the byte is good.
  - If the holding register is empty, or `rx_ready` is high in that same cycle, load `rx_data` and set `rx_valid`.
  - Otherwise drop the new byte, keep the old one, and pulse `overrun`.
- Stop sample = 0: discard the byte, pulse `frame_err`, leave the holding register untouched.
- `rx_valid` clears on handshake, unless a new byte loads in that same cycle; in that case it stays high with the new data.
- Counter width is `$clog2(CLKS_PER_BIT)`. Counters never wrap within a bit; they clear on every sample.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE.
- Reset asserted mid-character aborts the character immediately. No pulse is emitted and the held byte is lost.
- Synchronizer latency is 2 cycles from a line transition to the synced value. Edge detection adds 1 more.
- Latency is counted from the rising edge of the cycle in which the stop bit is sampled:
  - `rx_valid` or `frame_err` or `overrun` asserts on that same edge.
  - `frame_err` and `overrun` stay high for exactly one cycle.
- `busy` rises on the edge entering START and falls on the edge leaving STOP.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state after DATA, with one extra sample at `CLKS_PER_BIT` cycles.
  - Checks even parity (XOR of the 8 data bits and the parity bit must be 0).
  - Adds output `parity_err` (1 bit, reset 0). It pulses in the stop-sample cycle when the check fails.
  - A byte with bad parity is discarded like a framing error. If both faults occur, both pulses fire.
- Undefined: 8N1 only, no PARITY state, no `parity_err` port.

## Structure
- `uart_pkg`:
  - FSM state enum.
  - Default `CLKS_PER_BIT`.
  - `UART_DATA_W` = 8.
  - Idle line level constant.
- Sub-module `rx_sync`: 2-FF synchronizer plus edge register. Outputs `rx_s` and `rx_fall`. It is reused by any future serial input.

## Test plan
All scenarios run with `CLKS_PER_BIT` = 8.
- Send 0xA5 8N1 with `rx_ready`=1 → `rx_valid` pulses for one cycle with `rx_data`=0xA5; `frame_err`=0, `overrun`=0.
- Send 0x3C then 0x81 back-to-back (one stop bit) with `rx_ready`=1 → two valid bytes 0x3C then 0x81, no errors.
- Send 0x55 with the stop bit forced low → `frame_err` one-cycle pulse, `rx_valid` stays 0; the next clean 0x12 is received correctly.
- Hold `rx_ready`=0, send 0x11 then 0x22 → `rx_data`=0x11 held, `overrun` pulses at the 0x22 stop sample. Raising `rx_ready` then yields 0x11 only.
- Drive a 2-cycle low glitch on an idle line → FSM returns to IDLE and no outputs change. Assert `reset` low mid-DATA of a character → all outputs 0 and `busy`=0 immediately.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 (wrong) → `parity_err` pulse, no `rx_valid`; with parity bit 1 → `rx_data`=0x07.
